// File: rtl/encrypt_buffer_if.sv
// Byte-in / block-out bus of the encrypt buffer: control-unit byte stream,
// back-pressure, and the 128-bit block handshake toward the AES core.
interface encrypt_buffer_if;
  logic [7:0]   write;
  logic         write_enable;
  logic         eop_enable;
  logic         encrypt_full;
  logic [127:0] block;
  logic         block_valid;
  logic         block_ready;
  logic [4:0]   block_len;
  logic         block_last;
  logic         overflow;

  modport master (
    output write, write_enable, eop_enable, block_ready,
    input  encrypt_full, block, block_valid, block_len, block_last, overflow
  );

  modport slave (
    input  write, write_enable, eop_enable, block_ready,
    output encrypt_full, block, block_valid, block_len, block_last, overflow
  );
endinterface

// File: rtl/encrypt_buffer.sv
// Packs a byte stream MSB-first into zero-padded 128-bit blocks and hands them
// to the AES core through a one-block holding register.
module encrypt_buffer (
  input  logic           clk,
  input  logic           rst,
  encrypt_buffer_if.slave bus
);

  typedef enum logic [0:0] {
    ASM_OPEN   = 1'b0,
    ASM_SEALED = 1'b1
  } asm_state_t;

  asm_state_t   state_r;
  asm_state_t   state_nxt_s;
  logic [127:0] asm_data_r;
  logic [127:0] asm_data_nxt_s;
  logic [4:0]   asm_cnt_r;
  logic [4:0]   asm_cnt_nxt_s;
  logic         asm_last_r;
  logic         asm_last_nxt_s;

  logic [127:0] block_r;
  logic [4:0]   block_len_r;
  logic         block_last_r;
  logic         block_valid_r;
  logic         overflow_r;

  logic         sealed_s;
  logic         accept_wr_s;
  logic         accept_eop_s;
  logic         transfer_s;
  logic         drain_s;
  logic         reject_s;

  // Unwritten lanes are always zero, so a byte can be OR-ed into its lane.
  function automatic logic [127:0] place_byte(input logic [7:0] b, input logic [3:0] lane);
    place_byte = {b, 120'd0} >> {lane, 3'b000};
  endfunction

  // Handshake qualifiers shared by the assembly and holding sides.
  always_comb begin
    sealed_s     = (state_r == ASM_SEALED);
    accept_wr_s  = bus.write_enable & ~sealed_s;
    accept_eop_s = bus.eop_enable & ~sealed_s;
    reject_s     = sealed_s & (bus.write_enable | bus.eop_enable);
    transfer_s   = sealed_s & (~block_valid_r | bus.block_ready);
    drain_s      = block_valid_r & bus.block_ready & ~transfer_s;
  end

  // Assembly next-state: fill lanes, seal on 16th byte or EOP, clear on transfer.
  always_comb begin
    state_nxt_s    = state_r;
    asm_data_nxt_s = asm_data_r;
    asm_cnt_nxt_s  = asm_cnt_r;
    asm_last_nxt_s = asm_last_r;
    case (state_r)
      ASM_OPEN: begin
        if (accept_wr_s) begin
          asm_data_nxt_s = asm_data_r | place_byte(bus.write, asm_cnt_r[3:0]);
          asm_cnt_nxt_s  = asm_cnt_r + 5'd1;
        end else begin
          asm_data_nxt_s = asm_data_r;
          asm_cnt_nxt_s  = asm_cnt_r;
        end
        // An EOP riding on the 16th byte still marks the block as last.
        if (accept_eop_s || (accept_wr_s && (asm_cnt_r == 5'd15))) begin
          state_nxt_s    = ASM_SEALED;
          asm_last_nxt_s = accept_eop_s;
        end else begin
          state_nxt_s    = ASM_OPEN;
          asm_last_nxt_s = asm_last_r;
        end
      end
      ASM_SEALED: begin
        if (transfer_s) begin
          state_nxt_s    = ASM_OPEN;
          asm_data_nxt_s = 128'd0;
          asm_cnt_nxt_s  = 5'd0;
          asm_last_nxt_s = 1'b0;
        end else begin
          state_nxt_s    = ASM_SEALED;
        end
      end
      default: begin
        state_nxt_s    = ASM_OPEN;
        asm_data_nxt_s = 128'd0;
        asm_cnt_nxt_s  = 5'd0;
        asm_last_nxt_s = 1'b0;
      end
    endcase
  end

  // Assembly state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ASM_OPEN;
      asm_data_r <= 128'd0;
      asm_cnt_r  <= 5'd0;
      asm_last_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      asm_data_r <= asm_data_nxt_s;
      asm_cnt_r  <= asm_cnt_nxt_s;
      asm_last_r <= asm_last_nxt_s;
    end
  end

  // Holding register: refill on transfer (even while draining), else drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      block_r       <= 128'd0;
      block_len_r   <= 5'd0;
      block_last_r  <= 1'b0;
      block_valid_r <= 1'b0;
    end else if (transfer_s) begin
      block_r       <= asm_data_r;
      block_len_r   <= asm_cnt_r;
      block_last_r  <= asm_last_r;
      block_valid_r <= 1'b1;
    end else if (drain_s) begin
      block_valid_r <= 1'b0;
    end else begin
      block_valid_r <= block_valid_r;
    end
  end

  // Sticky overflow for input offered while sealed.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r | reject_s;
    end
  end

  assign bus.encrypt_full = sealed_s;
  assign bus.block        = block_r;
  assign bus.block_valid  = block_valid_r;
  assign bus.block_len    = block_len_r;
  assign bus.block_last   = block_last_r;
  assign bus.overflow     = overflow_r;

endmodule
